// File: rtl/conv_pkg.sv
// Definitions shared by the Sobel convolution core and its result streamer:
// FSM encoding, pixel/tag widths, BRAM address stride and default frame size.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int PIX_W          = 8;
    localparam int TAG_W          = 2;
    localparam int FIFO_W         = PIX_W + TAG_W;
    localparam int ADDR_STRIDE    = 4;
    localparam int IMG_WIDTH_DEF  = 256;
    localparam int IMG_HEIGHT_DEF = 256;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding {pixel, tlast, tuser} between the BRAM read
// pipeline and the output byte stream. Head entry is visible combinationally.
module stream_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FIFO_W,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is still safe when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Walks the Sobel result BRAM in raster order and streams each magnitude byte
// on a valid/ready stream with row-end (tlast) and frame-start (tuser) marks.
module result_streamer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [31:0] bram1_addr,
    output logic        bram1_en,
    input  logic [31:0] bram1_dout,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [31:0] rd_x_q, rd_x_d;
    logic [31:0] rd_y_q, rd_y_d;
    logic        all_issued_q, all_issued_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic        en_q, en_d;
    logic [31:0] addr_q, addr_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        done_q, done_d;
    logic        pend_q, pend_last_q, pend_user_q;

    logic              issue;
    logic              credit_ok;
    logic [31:0]       inflight;
    logic              xfer;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic [CW-1:0]     fifo_count;
    logic [23:0]       dout_hi_unused;

    assign dout_hi_unused = bram1_dout[31:8];

    // The read returning this cycle is captured with the tags issued alongside it.
    assign fifo_din = {bram1_dout[PIX_W-1:0], pend_last_q, pend_user_q};

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pend_q),
        .push_data_i (fifo_din),
        .pop_i       (xfer),
        .head_o      (fifo_head),
        .full_o      (fifo_full_unused),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_head[FIFO_W-1:TAG_W] : '0;
    assign m_tlast  = m_tvalid && fifo_head[1];
    assign m_tuser  = m_tvalid && fifo_head[0];
    assign xfer     = m_tvalid && m_tready;

    assign done       = done_q;
    assign bram1_en   = en_q;
    assign bram1_addr = addr_q;

    // Every read on the BRAM port or in the return stage has a FIFO slot reserved.
    assign inflight  = 32'(en_q) + 32'(pend_q) + 32'(fifo_count);
    assign credit_ok = (inflight < 32'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        rd_x_d       = rd_x_q;
        rd_y_d       = rd_y_q;
        all_issued_d = all_issued_q;
        out_cnt_d    = out_cnt_q;
        en_d         = 1'b0;
        addr_d       = '0;
        tlast_d      = 1'b0;
        tuser_d      = 1'b0;
        issue        = 1'b0;

        if (xfer) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    issue   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (all_issued_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (xfer && (out_cnt_q == 32'(TOTAL - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rd_x_d       = '0;
                rd_y_d       = '0;
                all_issued_d = 1'b0;
                out_cnt_d    = '0;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            en_d    = 1'b1;
            addr_d  = (rd_y_q * 32'(IMG_WIDTH) + rd_x_q) * 32'(ADDR_STRIDE);
            tlast_d = (rd_x_q == 32'(IMG_WIDTH - 1));
            tuser_d = (rd_x_q == '0) && (rd_y_q == '0);
            if (rd_x_q == 32'(IMG_WIDTH - 1)) begin
                rd_x_d = '0;
                if (rd_y_q == 32'(IMG_HEIGHT - 1)) begin
                    all_issued_d = 1'b1;
                end else begin
                    rd_y_d = rd_y_q + 32'd1;
                end
            end else begin
                rd_x_d = rd_x_q + 32'd1;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            all_issued_q <= 1'b0;
            out_cnt_q    <= '0;
            en_q         <= 1'b0;
            addr_q       <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_user_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            all_issued_q <= all_issued_d;
            out_cnt_q    <= out_cnt_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            done_q       <= done_d;
            pend_q       <= en_q;
            pend_last_q  <= tlast_q;
            pend_user_q  <= tuser_q;
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: three frame geometries (4x2, 16x16, 1x3) with
// behavioural BRAM models and per-instance expected-pixel queues.
module tb_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i, input int seed);
        return 32'h100 + 32'(i * 17) + 32'(seed);
    endfunction

    function automatic logic [9:0] exp_ent(input int i, input int w, input int seed);
        logic [31:0] wd;
        wd = word(i, seed);
        return {wd[7:0], 1'((i % w) == (w - 1)), 1'(i == 0)};
    endfunction

    // ---------------- instance A: 4x2 ----------------
    logic        start_a, done_a, en_a, tvalid_a, tready_a, tlast_a, tuser_a;
    logic [31:0] addr_a, dout_a;
    logic [7:0]  tdata_a;
    int          seed_a = 0;

    result_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .done(done_a),
        .bram1_addr(addr_a), .bram1_en(en_a), .bram1_dout(dout_a),
        .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(tready_a),
        .m_tlast(tlast_a), .m_tuser(tuser_a)
    );

    always @(posedge clk) if (en_a) dout_a <= word(int'(addr_a >> 2), seed_a);

    logic [9:0] exp_a[$];
    int         reads_a = 0, xfer_a = 0, first_a = 0, last_a = 0;
    logic       stall_a = 1'b0;
    logic [9:0] held_a;

    always @(negedge clk) begin
        if (rst) begin
            reads_a = 0;
            xfer_a  = 0;
            stall_a = 1'b0;
        end else begin
            chk("a_credit", 32'((reads_a + int'(en_a) - xfer_a) <= 4), 32'd1);
            if (stall_a) chk("a_stable", {tvalid_a, tdata_a, tlast_a, tuser_a}, {1'b1, held_a});
            if (en_a) reads_a++;
            if (tvalid_a && tready_a) begin
                if (xfer_a == 0) first_a = cyc;
                last_a = cyc;
                xfer_a++;
                chk("a_unexp", 32'(exp_a.size() > 0), 32'd1);
                if (exp_a.size() > 0) chk("a_pixel", {tdata_a, tlast_a, tuser_a}, exp_a.pop_front());
            end
            stall_a = tvalid_a && !tready_a;
            held_a  = {tdata_a, tlast_a, tuser_a};
        end
    end

    // ---------------- instance B: 16x16 ----------------
    logic        start_b, done_b, en_b, tvalid_b, tready_b, tlast_b, tuser_b;
    logic [31:0] addr_b, dout_b;
    logic [7:0]  tdata_b;
    int          seed_b = 3;

    result_streamer #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .done(done_b),
        .bram1_addr(addr_b), .bram1_en(en_b), .bram1_dout(dout_b),
        .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(tready_b),
        .m_tlast(tlast_b), .m_tuser(tuser_b)
    );

    always @(posedge clk) if (en_b) dout_b <= word(int'(addr_b >> 2), seed_b);

    logic [9:0] exp_b[$];
    int         reads_b = 0, xfer_b = 0;
    int         rdcnt_b [256];

    always @(negedge clk) begin
        if (rst) begin
            reads_b = 0;
            xfer_b  = 0;
            foreach (rdcnt_b[k]) rdcnt_b[k] = 0;
        end else begin
            chk("b_credit", 32'((reads_b + int'(en_b) - xfer_b) <= 4), 32'd1);
            if (en_b) begin
                reads_b++;
                rdcnt_b[addr_b[9:2]]++;
            end
            if (tvalid_b && tready_b) begin
                xfer_b++;
                chk("b_unexp", 32'(exp_b.size() > 0), 32'd1);
                if (exp_b.size() > 0) chk("b_pixel", {tdata_b, tlast_b, tuser_b}, exp_b.pop_front());
            end
        end
    end

    // ---------------- instance C: 1x3 ----------------
    logic        start_c, done_c, en_c, tvalid_c, tready_c, tlast_c, tuser_c;
    logic [31:0] addr_c, dout_c;
    logic [7:0]  tdata_c;
    int          seed_c = 7;

    result_streamer #(.IMG_WIDTH(1), .IMG_HEIGHT(3), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .done(done_c),
        .bram1_addr(addr_c), .bram1_en(en_c), .bram1_dout(dout_c),
        .m_tdata(tdata_c), .m_tvalid(tvalid_c), .m_tready(tready_c),
        .m_tlast(tlast_c), .m_tuser(tuser_c)
    );

    always @(posedge clk) if (en_c) dout_c <= word(int'(addr_c >> 2), seed_c);

    logic [9:0] exp_c[$];

    always @(negedge clk) begin
        if (!rst && tvalid_c && tready_c) begin
            chk("c_unexp", 32'(exp_c.size() > 0), 32'd1);
            if (exp_c.size() > 0) chk("c_pixel", {tdata_c, tlast_c, tuser_c}, exp_c.pop_front());
        end
    end

    task automatic check_a_zero(input string pfx);
        chk({pfx, "_done"},   32'(done_a),   32'd0);
        chk({pfx, "_en"},     32'(en_a),     32'd0);
        chk({pfx, "_addr"},   addr_a,        32'd0);
        chk({pfx, "_tvalid"}, 32'(tvalid_a), 32'd0);
        chk({pfx, "_tdata"},  32'(tdata_a),  32'd0);
        chk({pfx, "_tlast"},  32'(tlast_a),  32'd0);
        chk({pfx, "_tuser"},  32'(tuser_a),  32'd0);
    endtask

    task automatic wait_done_a(output int dc);
        for (int n = 0; n < 200 && !done_a; n++) begin
            @(posedge clk); #1;
        end
        dc = cyc;
        chk("a_done_seen", 32'(done_a), 32'd1);
    endtask

    task automatic frame_a(input int seed);
        seed_a = seed;
        for (int i = 0; i < 8; i++) exp_a.push_back(exp_ent(i, 4, seed));
    endtask

    initial begin
        int s, dc, x0, bad;
        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        tready_a = 0; tready_b = 0; tready_c = 0;
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("rst");
        chk("rst_b_tvalid", 32'(tvalid_b), 32'd0);
        chk("rst_c_done", 32'(done_c), 32'd0);
        rst = 1'b0;

        // full-rate 4x2 frame
        frame_a(0);
        tready_a = 1;
        @(posedge clk); #1;
        start_a = 1; s = cyc;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(dc);
        chk("t1_drained", 32'(exp_a.size()), 32'd0);
        chk("t1_latency", 32'((first_a - s) <= 3), 32'd1);
        chk("t1_span", 32'(last_a - first_a), 32'd7);
        chk("t1_done_lat", 32'(dc - last_a), 32'd1);
        @(posedge clk); #1;
        chk("t1_idle_done", 32'(done_a), 32'd0);

        // backpressure mid-frame
        frame_a(5);
        x0 = xfer_a;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        for (int n = 0; n < 50 && xfer_a < x0 + 2; n++) begin
            @(posedge clk); #1;
        end
        tready_a = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("t2_stall_fill", 32'(reads_a + int'(en_a) - xfer_a), 32'd4);
        chk("t2_stall_en", 32'(en_a), 32'd0);
        tready_a = 1;
        wait_done_a(dc);
        chk("t2_drained", 32'(exp_a.size()), 32'd0);
        @(posedge clk); #1;

        // start held high through DONE
        frame_a(0);
        start_a = 1;
        wait_done_a(dc);
        repeat (10) begin
            @(posedge clk); #1;
            chk("t4_done_hold", 32'(done_a), 32'd1);
            chk("t4_no_read", 32'(en_a), 32'd0);
        end
        start_a = 0;
        @(posedge clk); #1;
        chk("t4_idle_done", 32'(done_a), 32'd0);
        chk("t4_drained", 32'(exp_a.size()), 32'd0);
        frame_a(0);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(dc);
        chk("t4_second", 32'(exp_a.size()), 32'd0);
        @(posedge clk); #1;

        // reset after 5 transfers
        frame_a(9);
        x0 = xfer_a;
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        for (int n = 0; n < 50 && xfer_a < x0 + 5; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_a_zero("t5_rst");
        exp_a.delete();
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_idle_en", 32'(en_a), 32'd0);
            chk("t5_idle_tvalid", 32'(tvalid_a), 32'd0);
        end
        frame_a(9);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_done_a(dc);
        chk("t5_drained", 32'(exp_a.size()), 32'd0);

        // 16x16 with random ready
        for (int i = 0; i < 256; i++) exp_b.push_back(exp_ent(i, 16, seed_b));
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        for (int n = 0; n < 5000 && !done_b; n++) begin
            tready_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("t3_done", 32'(done_b), 32'd1);
        chk("t3_drained", 32'(exp_b.size()), 32'd0);
        chk("t3_reads", 32'(reads_b), 32'd256);
        bad = 0;
        foreach (rdcnt_b[k]) if (rdcnt_b[k] != 1) bad++;
        chk("t3_addr_once", 32'(bad), 32'd0);

        // single-column frame
        for (int i = 0; i < 3; i++) exp_c.push_back(exp_ent(i, 1, seed_c));
        tready_c = 1;
        start_c = 1;
        @(posedge clk); #1;
        start_c = 0;
        for (int n = 0; n < 100 && !done_c; n++) begin
            @(posedge clk); #1;
        end
        chk("t6_done", 32'(done_c), 32'd1);
        chk("t6_drained", 32'(exp_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
